// File: rtl/clock_gen_pkg.sv
// Shared types and helpers for the clock generator: phase-state enum, phase-length
// functions and default parameter values.
package clock_gen_pkg;

  localparam int unsigned DEFAULT_PERIOD = 10;
  localparam int unsigned DEFAULT_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    HIGH_PH,
    LOW_PH
  } phase_e;

  // High phase takes the extra cycle of an odd period.
  function automatic int unsigned high_len(input int unsigned period);
    return period - period / 2;
  endfunction

  function automatic int unsigned low_len(input int unsigned period);
    return period / 2;
  endfunction

endpackage

// File: rtl/clock_gen_phase.sv
// Phase counter and state machine: produces the registered divided clock and its
// single-cycle rise/fall strobes; rise_next_o flags the edge that will raise clk_out.
module clock_gen_phase
  import clock_gen_pkg::*;
#(
  parameter int unsigned PERIOD = DEFAULT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic clk_out_o,
  output logic rise_tick_o,
  output logic fall_tick_o,
  output logic rise_next_o
);

  localparam int unsigned HighLen = high_len(PERIOD);
  localparam int unsigned LowLen  = low_len(PERIOD);
  localparam int unsigned CntW    = (HighLen > 1) ? $clog2(HighLen) : 1;

  // Counter holds the cycles remaining in the current phase after this one.
  localparam logic [CntW-1:0] HighLast = CntW'(HighLen - 1);
  localparam logic [CntW-1:0] LowLast  = CntW'(LowLen - 1);

  phase_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_out_q, clk_out_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d   = HIGH_PH;
          cnt_d     = HighLast;
          clk_out_d = 1'b1;
          rise_d    = 1'b1;
        end
      end
      HIGH_PH: begin
        if (cnt_q == '0) begin
          state_d   = LOW_PH;
          cnt_d     = LowLast;
          clk_out_d = 1'b0;
          fall_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      LOW_PH: begin
        if (cnt_q == '0) begin
          // en only matters here, at the period boundary.
          if (en_i) begin
            state_d   = HIGH_PH;
            cnt_d     = HighLast;
            clk_out_d = 1'b1;
            rise_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign clk_out_o   = clk_out_q;
  assign rise_tick_o = rise_q;
  assign fall_tick_o = fall_q;
  assign rise_next_o = rise_d;

endmodule

// File: rtl/clock_gen.sv
// Clock generator/divider top: phase FSM plus a rise counter, which is built only
// when CLOCK_GEN_CYCLE_COUNT_EN is defined (otherwise cycle_count is tied to zero).
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int unsigned PERIOD = DEFAULT_PERIOD,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] cycle_count
);

  if (PERIOD < 2) begin : g_bad_period
    $error("clock_gen: PERIOD must be >= 2");
  end

  logic rise_next;

  clock_gen_phase #(
    .PERIOD(PERIOD)
  ) u_phase (
    .clk_i      (clk),
    .rst_ni     (reset),
    .en_i       (en),
    .clk_out_o  (clk_out),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick),
    .rise_next_o(rise_next)
  );

`ifdef CLOCK_GEN_CYCLE_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Counts on the same edge that raises clk_out; wraps silently.
  always_comb begin
    count_d = count_q;
    if (rise_next) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign cycle_count = count_q;
`else
  logic unused_rise_next;
  assign unused_rise_next = rise_next;
  assign cycle_count      = '0;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Bench for clock_gen: three instances (PERIOD 10/3/2) share clock, reset and enable
// and are compared every reference cycle against a period-position reference model.
module tb_clock_gen;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  logic en;

  logic        co0, rt0, ft0, co1, rt1, ft1, co2, rt2, ft2;
  logic [31:0] cc0, cc1;
  logic [3:0]  cc2;

  clock_gen #(.PERIOD(10), .CNT_W(32)) dut10 (
    .clk(clk), .reset(reset), .en(en), .clk_out(co0), .rise_tick(rt0), .fall_tick(ft0),
    .cycle_count(cc0)
  );
  clock_gen #(.PERIOD(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .en(en), .clk_out(co1), .rise_tick(rt1), .fall_tick(ft1),
    .cycle_count(cc1)
  );
  clock_gen #(.PERIOD(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .en(en), .clk_out(co2), .rise_tick(rt2), .fall_tick(ft2),
    .cycle_count(cc2)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Reference model: running flag, position within the period, rises seen.
  int unsigned per_a[N];
  int unsigned cw_a[N];
  bit          m_act[N];
  int unsigned m_pos[N];
  logic [31:0] m_cnt[N];

`ifdef CLOCK_GEN_CYCLE_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  function automatic logic [34:0] obs(input int d);
    case (d)
      0:       return {co0, rt0, ft0, cc0};
      1:       return {co1, rt1, ft1, cc1};
      default: return {co2, rt2, ft2, 28'd0, cc2};
    endcase
  endfunction

  function automatic logic [34:0] expv(input int d);
    int unsigned hi;
    logic [31:0] mask, cnt;
    hi   = per_a[d] - per_a[d] / 2;
    mask = (cw_a[d] >= 32) ? 32'hffff_ffff : ((32'd1 << cw_a[d]) - 32'd1);
    cnt  = CountEn ? (m_cnt[d] & mask) : 32'd0;
    return {m_act[d] && (m_pos[d] < hi), m_act[d] && (m_pos[d] == 0),
            m_act[d] && (m_pos[d] == hi), cnt};
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < N; d++) begin
      m_act[d] = 1'b0;
      m_pos[d] = 0;
      m_cnt[d] = 32'd0;
    end
  endfunction

  // One reference edge: model follows the edge, then we sit at the falling edge.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      if (!reset) continue;
      if (!m_act[d]) begin
        if (en) begin
          m_act[d] = 1'b1;
          m_pos[d] = 0;
          m_cnt[d] = m_cnt[d] + 1;
        end
      end else begin
        m_pos[d] = m_pos[d] + 1;
        if (m_pos[d] == per_a[d]) begin
          if (en) begin
            m_pos[d] = 0;
            m_cnt[d] = m_cnt[d] + 1;
          end else begin
            m_act[d] = 1'b0;
            m_pos[d] = 0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic restart();
    reset = 1'b0;
    en    = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < N; d++) begin
      vectors++;
      if (obs(d) !== 35'd0) begin
        errors++;
        $display("FAIL reset_async dut%0d got=%h want=%h", d, obs(d), 35'd0);
      end
    end
    repeat (3) begin
      step();
      for (int d = 0; d < N; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL reset_hold dut%0d got=%h want=%h", d, obs(d), expv(d));
        end
      end
    end
  endtask

  task automatic test_run();
    restart();
    en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      for (int d = 0; d < N; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL run dut%0d cyc%0d got=%h want=%h", d, k, obs(d), expv(d));
        end
      end
      vectors++;
      if ({rt0, ft0, co0} !== {(k % 10) == 1, (k % 10) == 6, ((k - 1) % 10) < 5}) begin
        errors++;
        $display("FAIL run_p10 cyc%0d got rt/ft/co=%b%b%b", k, rt0, ft0, co0);
      end
    end
    vectors++;
    if (CountEn && cc1 !== 32'd10) begin
      errors++;
      $display("FAIL run_p3_count got=%0d want=10", cc1);
    end
  endtask

  task automatic test_disable();
    restart();
    en = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      if (k == 13) en = 1'b0;
      if (k == 31) en = 1'b1;
      step();
      for (int d = 0; d < N; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL disable dut%0d cyc%0d got=%h want=%h", d, k, obs(d), expv(d));
        end
      end
      if (k == 21 || k == 31) begin
        vectors++;
        if ({rt0, cc0} !== {k == 31, CountEn ? ((k == 31) ? 32'd3 : 32'd2) : 32'd0}) begin
          errors++;
          $display("FAIL disable_p10 cyc%0d got rt=%b cnt=%0d", k, rt0, cc0);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    restart();
    en = 1'b1;
    repeat (3) step();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < N; d++) begin
      vectors++;
      if (obs(d) !== 35'd0) begin
        errors++;
        $display("FAIL mid_reset dut%0d got=%h want=0", d, obs(d));
      end
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int d = 0; d < N; d++) begin
      vectors++;
      if (obs(d) !== expv(d)) begin
        errors++;
        $display("FAIL mid_reset_restart dut%0d got=%h want=%h", d, obs(d), expv(d));
      end
    end
    vectors++;
    if ({co0, rt0, cc0} !== {2'b11, CountEn ? 32'd1 : 32'd0}) begin
      errors++;
      $display("FAIL mid_reset_p10 got co/rt=%b%b cnt=%0d", co0, rt0, cc0);
    end
  endtask

  task automatic test_wrap();
    restart();
    en = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      for (int d = 0; d < N; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL wrap dut%0d cyc%0d got=%h want=%h", d, k, obs(d), expv(d));
        end
      end
      // PERIOD=2: the 16th rise lands on cycle 31 and must wrap to 0.
      if (k == 31 || k == 33) begin
        vectors++;
        if (cc2 !== (CountEn ? ((k == 31) ? 4'd0 : 4'd1) : 4'd0)) begin
          errors++;
          $display("FAIL wrap_p2 cyc%0d got=%0d", k, cc2);
        end
      end
    end
  endtask

  task automatic test_random();
    restart();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      step();
      for (int d = 0; d < N; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          errors++;
          $display("FAIL random dut%0d it%0d en=%b got=%h want=%h", d, k, en, obs(d), expv(d));
        end
      end
    end
  endtask

  initial begin
    per_a = '{10, 3, 2};
    cw_a  = '{32, 32, 4};
    test_reset();
    test_run();
    test_disable();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/clock_gen.md
Name: clock_gen

Overview:
- Synthesizable clock generator/divider for the processor bench and core.
- Derives a divided, roughly 50%-duty clock `clk_out` from a reference clock `clk`.
- Provides single-cycle rise/fall strobes and a running count of generated cycles, used as the pipeline "Cycle:" counter.
- Sits at top level and feeds the pipeline stages and the cycle-count display.

Parameters:
- PERIOD, 10, output period in reference-clock cycles; must be >= 2; elaboration error otherwise.
- CNT_W, 32, width of `cycle_count`.

Ports:
- clk  input  1  reference clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- en  input  1  run enable; sampled only at period boundaries.
- clk_out  output  1  generated clock, registered, glitch-free.
- rise_tick  output  1  high for exactly one ref cycle, the one in which `clk_out` first reads 1.
- fall_tick  output  1  high for exactly one ref cycle, the one in which `clk_out` first reads 0.
- cycle_count  output  CNT_W  number of `clk_out` rising edges since reset.

Behaviour:
- Phase widths:
  - HIGH = PERIOD - PERIOD/2 (ceiling).
  - LOW = PERIOD/2 (floor).
  - Examples: PERIOD=10 gives 5/5; PERIOD=3 gives 2/1.
- Reset (reset=0, asynchronous):
  - `clk_out`=0, `rise_tick`=0, `fall_tick`=0, `cycle_count`=0.
  - Phase counter idle.
  - Applies immediately, mid-period included; no partial pulse completes.
- Start:
  - From idle, the first rising `clk` edge sampling en=1 sets `clk_out`=1, `rise_tick`=1, and increments `cycle_count`, all on that same edge.
  - Latency is 1 ref cycle from en seen high.
- Run:
  - `clk_out` stays high for HIGH ref cycles, then low for LOW ref cycles.
  - At the end of the low phase, if en=1, the next rise occurs on the immediately following edge. This gives a seamless period of exactly PERIOD ref cycles.
- Disable:
  - en=0 sampled anywhere in a period does not truncate it; high and low phases complete.
  - At the end of the low phase, if en=0, the generator returns to idle with `clk_out`=0.
  - Restart follows the start rule.
- Ticks:
  - Registered, mutually exclusive, each exactly 1 ref cycle wide.
  - `fall_tick` asserts on the edge where `clk_out` goes 1 to 0.
- `cycle_count`:
  - Increments by 1 per rise.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Holds while idle.
- Only `clk_out`'s register drives `clk_out`; no combinational gating of `clk`.

Optional Feature:
- CLOCK_GEN_CYCLE_COUNT_EN
  - Defined: `cycle_count` counter implemented as above.
  - Undefined: counter logic removed and `cycle_count` tied to all-zeros. Port list is unchanged and the other outputs are identical.

Decomposition:
- Package `clock_gen_pkg` holds:
  - functions `high_len(PERIOD)` and `low_len(PERIOD)`;
  - default constants DEFAULT_PERIOD=10 and DEFAULT_CNT_W=32;
  - phase-state enum IDLE/HIGH_PH/LOW_PH.
- One natural sub-module `clock_gen_phase`: phase counter plus state machine producing `clk_out`, `rise_tick` and `fall_tick`. The top adds the cycle counter and the macro handling.

Test Plan:
- PERIOD=10, en=1, reset released → `clk_out` 1 on the first edge, high 5 / low 5 repeating. `rise_tick` at ref cycles 1, 11, 21 and `fall_tick` at 6, 16, 26. `cycle_count` reads 1, 2, 3 at those rises.
- PERIOD=3 → pattern 1,1,0 repeating; `cycle_count` reaches 4 after 12 ref cycles.
- PERIOD=10, en dropped at ref cycle 13 (high phase) → period completes, `clk_out` low from cycle 16 onward. No `rise_tick` at 21; `cycle_count` holds at 2. Re-raising en at cycle 30 → rise at cycle 31 and `cycle_count`=3.
- Assert reset=0 at ref cycle 3 (mid-high) → `clk_out`, ticks and `cycle_count` all 0 immediately. After release with en=1, the rise occurs on the next edge and `cycle_count`=1.
- CNT_W=4, PERIOD=2, en=1 → `cycle_count` 1..15 then 0 at the 16th rise; 1 at the 17th.
- Built without CLOCK_GEN_CYCLE_COUNT_EN, PERIOD=10 → `cycle_count` constantly 0; `clk_out` and tick timing identical to the first scenario.
